// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - bus widths, ALU/divider encodings and bus layouts for the execute stage
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 151;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_TO_DS_BUS_WD = 38;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam int DIV_EN     = 2;
  localparam int DIV_SIGNED = 1;
  localparam int DIV_REM    = 0;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef struct packed {
    logic [2:0]  div_op;
    logic [11:0] alu_op;
    logic        res_from_mem;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_bus_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  // alu_op is one-hot, so the masked results can simply be OR-ed together
  function automatic logic [31:0] alu_eval(input logic [11:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    r  = '0;
    r  = r | ({32{op[ALU_ADD]}}  & (a + b));
    r  = r | ({32{op[ALU_SUB]}}  & (a - b));
    r  = r | ({32{op[ALU_SLT]}}  & {31'd0, $signed(a) < $signed(b)});
    r  = r | ({32{op[ALU_SLTU]}} & {31'd0, a < b});
    r  = r | ({32{op[ALU_AND]}}  & (a & b));
    r  = r | ({32{op[ALU_NOR]}}  & ~(a | b));
    r  = r | ({32{op[ALU_OR]}}   & (a | b));
    r  = r | ({32{op[ALU_XOR]}}  & (a ^ b));
    r  = r | ({32{op[ALU_SLL]}}  & (a << sh));
    r  = r | ({32{op[ALU_SRL]}}  & (a >> sh));
    r  = r | ({32{op[ALU_SRA]}}  & $unsigned($signed(a) >>> sh));
    r  = r | ({32{op[ALU_LUI]}}  & b);
    return r;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - decode/exe/mem pipeline handshake and bus bundle
interface exe_stage_if;
  import exe_stage_pkg::*;

  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus;

  modport master (
    input  ds_to_es_valid, ds_to_es_bus, ms_allowin,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus
  );

  modport slave (
    output ds_to_es_valid, ds_to_es_bus, ms_allowin,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus
  );
endinterface

// File: rtl/exe_stage_div.sv
// rtl/exe_stage_div.sv - iterative restoring 32-bit divider (exe_div), built only with EXE_DIV_EN
`ifdef EXE_DIV_EN
module exe_div
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  input  logic        ack,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [63:0] part;
  logic [31:0] dvsr;
  logic        q_neg;
  logic        r_neg;
  logic        div_zero;
  logic [31:0] quo_r;
  logic [31:0] rem_r;

  logic [32:0] hi;
  logic [31:0] sub;
  logic        fits;
  logic [63:0] part_next;

  // hi keeps bit 32 so a remainder close to a large divisor is not truncated by the shift
  always_comb begin
    hi        = part[63:31];
    fits      = hi >= {1'b0, dvsr};
    sub       = hi[31:0] - dvsr;
    part_next = fits ? {sub, part[30:0], 1'b1} : {hi[31:0], part[30:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      part     <= '0;
      dvsr     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      quo_r    <= '0;
      rem_r    <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          dvsr     <= (is_signed && divisor[31]) ? -divisor : divisor;
          part     <= {32'd0, (is_signed && dividend[31]) ? -dividend : dividend};
          q_neg    <= is_signed & (dividend[31] ^ divisor[31]);
          r_neg    <= is_signed & dividend[31];
          div_zero <= (divisor == 32'd0);
          cnt      <= '0;
          state    <= DIV_BUSY;
        end
        DIV_BUSY: if (cnt == 6'd32) begin
          // final cycle applies the sign fixup; results then stay frozen through DONE
          quo_r <= div_zero ? 32'hFFFF_FFFF : (q_neg ? -part[31:0] : part[31:0]);
          rem_r <= r_neg ? -part[63:32] : part[63:32];
          state <= DIV_DONE;
        end else begin
          part <= part_next;
          cnt  <= cnt + 6'd1;
        end
        DIV_DONE: if (ack) state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign done      = (state == DIV_DONE);
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule
`endif

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - pipeline execute stage: ALU, optional divider (EXE_DIV_EN), SRAM request, hazard bus
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  exe_stage_if.master pipe,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  logic        es_valid;
  ds_bus_t     es_bus;
  logic        es_ready_go;
  logic        es_allowin;
  logic        div_en;
  logic        div_blk;
  logic [31:0] div_result;
  logic [31:0] alu_out;
  logic [31:0] alu_result;
  es_bus_t     ms_bus;

  assign div_en     = es_bus.div_op[DIV_EN];
  assign es_allowin = !es_valid | (es_ready_go & pipe.ms_allowin);

  always_ff @(posedge clk) begin
    if (reset)           es_valid <= 1'b0;
    else if (es_allowin) es_valid <= pipe.ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)                                   es_bus <= '0;
    else if (pipe.ds_to_es_valid && es_allowin)  es_bus <= pipe.ds_to_es_bus;
  end

`ifdef EXE_DIV_EN
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  exe_div u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (es_valid & div_en),
    .dividend  (es_bus.src1),
    .divisor   (es_bus.src2),
    .is_signed (es_bus.div_op[DIV_SIGNED]),
    .ack       (es_valid & pipe.ms_allowin),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign es_ready_go = !div_en | div_done;
  assign div_result  = es_bus.div_op[DIV_REM] ? div_rem : div_quo;
  assign div_blk     = div_en & !div_done;
`else
  logic unused_div_bits;
  assign unused_div_bits = ^es_bus.div_op[DIV_SIGNED:DIV_REM];
  assign es_ready_go     = 1'b1;
  assign div_result      = 32'd0;
  assign div_blk         = 1'b0;
`endif

  assign alu_out    = alu_eval(es_bus.alu_op, es_bus.src1, es_bus.src2);
  assign alu_result = div_en ? div_result : alu_out;

  assign ms_bus.res_from_mem = es_bus.res_from_mem;
  assign ms_bus.gr_we        = es_bus.gr_we;
  assign ms_bus.dest         = es_bus.dest;
  assign ms_bus.alu_result   = alu_result;
  assign ms_bus.pc           = es_bus.pc;

  assign pipe.es_allowin     = es_allowin;
  assign pipe.es_to_ms_valid = es_valid & es_ready_go;
  assign pipe.es_to_ms_bus   = ms_bus;

  // a load or an unfinished divide cannot be forwarded yet, so decode must stall on a match
  assign pipe.es_to_ds_bus = {es_valid & (es_bus.res_from_mem | div_blk),
                              (es_valid & es_bus.gr_we) ? es_bus.dest : 5'd0,
                              alu_result};

  // request goes out only in the cycle the instruction moves into MEM
  assign data_sram_en    = es_valid & pipe.ms_allowin & (es_bus.res_from_mem | es_bus.mem_we);
  assign data_sram_we    = {4{es_valid & pipe.ms_allowin & es_bus.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard bench for exe_stage; divider expectations follow EXE_DIV_EN
module tb_exe_stage;
  import exe_stage_pkg::*;

`ifdef EXE_DIV_EN
  localparam bit HAS_DIV = 1'b1;
`else
  localparam bit HAS_DIV = 1'b0;
`endif
  localparam int DIV_LAT = HAS_DIV ? 34 : 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  always #5 clk = ~clk;

  exe_stage_if pipe ();

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .pipe            (pipe),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  int          total = 0;
  int          bad   = 0;
  logic [70:0] exp_q[$];

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [150:0] mk(input logic [2:0] dop, input int op_idx, input logic rfm,
                                      input logic gw, input logic mw, input logic [4:0] dest,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] rkd, input logic [31:0] pc);
    logic [11:0] aop;
    aop = 12'd1 << op_idx;
    return {dop, aop, rfm, gw, mw, dest, s1, s2, rkd, pc};
  endfunction

  function automatic logic [70:0] ex(input logic rfm, input logic gw, input logic [4:0] dest,
                                     input logic [31:0] res, input logic [31:0] pc);
    return {rfm, gw, dest, res, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [150:0] b, input logic [70:0] e, input bit push);
    bit ok;
    ok = 1'b0;
    pipe.ds_to_es_valid = 1'b1;
    pipe.ds_to_es_bus   = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pipe.es_allowin) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 71'd0, 71'd1);
    if (push) exp_q.push_back(e);
    step();
    pipe.ds_to_es_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("drain_timeout", 71'(exp_q.size()), 71'd0);
    step();
  endtask

  // counts blocked cycles until the result is presented
  task automatic div_run(input string name, input logic [2:0] dop, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] expv, input logic [31:0] pc);
    int n;
    int nblk;
    bit got;
    n = 0; nblk = 0; got = 1'b0;
    issue(mk(dop, ALU_ADD, 1'b0, 1'b1, 1'b0, 5'd5, s1, s2, 32'd0, pc),
          ex(1'b0, 1'b1, 5'd5, HAS_DIV ? expv : 32'd0, pc), 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pipe.es_to_ms_valid) begin
        got = 1'b1;
        break;
      end
      n++;
      if (pipe.es_to_ds_bus[37]) nblk++;
    end
    chk({name, "_done"}, 71'(got), 71'd1);
    chk({name, "_latency"}, 71'(n), 71'(DIV_LAT));
    chk({name, "_blk_cycles"}, 71'(nblk), 71'(DIV_LAT));
    chk({name, "_blk_at_done"}, 71'(pipe.es_to_ds_bus[37]), 71'd0);
    drain();
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && pipe.es_to_ms_valid && pipe.ms_allowin) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h expected none", pipe.es_to_ms_bus);
        end else begin
          chk("ms_bus", pipe.es_to_ms_bus, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          alu_ops [0:10] = '{ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_NOR, ALU_OR,
                                  ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI};
  logic [31:0] alu_a   [0:10] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                                  32'hF0F0_F0F0, 32'h1234_0000, 32'hFFFF_0000, 32'h0000_0001,
                                  32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
  logic [31:0] alu_b   [0:10] = '{32'd7, 32'd1, 32'd1, 32'hFF00_FF00, 32'h0F0F_0000,
                                  32'h0000_5678, 32'h0F0F_0F0F, 32'h0000_0024, 32'd4, 32'd4,
                                  32'hABCD_0000};
  logic [31:0] alu_r   [0:10] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'hF000_F000, 32'h0000_0F0F,
                                  32'h1234_5678, 32'hF0F0_0F0F, 32'h0000_0010, 32'h0800_0000,
                                  32'hF800_0000, 32'hABCD_0000};

  initial begin : stim
    bit got;
    reset               = 1'b1;
    pipe.ds_to_es_valid = 1'b0;
    pipe.ds_to_es_bus   = '0;
    pipe.ms_allowin     = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_ms_valid", 71'(pipe.es_to_ms_valid), 71'd0);
    chk("rst_sram_en", 71'(data_sram_en), 71'd0);
    chk("rst_sram_we", 71'(data_sram_we), 71'd0);
    chk("rst_blk_fwd", 71'(pipe.es_to_ds_bus[37:32]), 71'd0);
    chk("rst_allowin", 71'(pipe.es_allowin), 71'd1);
    step();
    reset = 1'b0;

    issue(mk(3'b000, ALU_ADD, 1'b0, 1'b1, 1'b0, 5'd3, 32'd5, 32'd7, 32'd0, 32'h1C00_0000),
          ex(1'b0, 1'b1, 5'd3, 32'd12, 32'h1C00_0000), 1'b1);
    @(negedge clk);
    chk("add_valid", 71'(pipe.es_to_ms_valid), 71'd1);
    chk("add_fwd", 71'(pipe.es_to_ds_bus), 71'({1'b0, 5'd3, 32'd12}));
    step();

    for (int i = 0; i < 11; i++)
      issue(mk(3'b000, alu_ops[i], 1'b0, 1'b1, 1'b0, 5'(i + 8), alu_a[i], alu_b[i], 32'd0,
               32'h1C00_0100 + 32'(4 * i)),
            ex(1'b0, 1'b1, 5'(i + 8), alu_r[i], 32'h1C00_0100 + 32'(4 * i)), 1'b1);
    drain();

    pipe.ms_allowin = 1'b0;
    issue(mk(3'b000, ALU_ADD, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0F00, 32'h0000_0100,
             32'hDEAD_BEEF, 32'h1C00_0200),
          ex(1'b0, 1'b0, 5'd0, 32'h0000_1000, 32'h1C00_0200), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sw_stall_en", 71'(data_sram_en), 71'd0);
      chk("sw_stall_we", 71'(data_sram_we), 71'd0);
      step();
    end
    pipe.ms_allowin = 1'b1;
    @(negedge clk);
    chk("sw_en", 71'(data_sram_en), 71'd1);
    chk("sw_we", 71'(data_sram_we), 71'hF);
    chk("sw_addr", 71'(data_sram_addr), 71'h1000);
    chk("sw_wdata", 71'(data_sram_wdata), 71'hDEAD_BEEF);
    drain();

    issue(mk(3'b000, ALU_ADD, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_2000, 32'd0, 32'd0,
             32'h1C00_0300),
          ex(1'b1, 1'b1, 5'd4, 32'h0000_2000, 32'h1C00_0300), 1'b1);
    @(negedge clk);
    chk("lw_ds_bus", 71'(pipe.es_to_ds_bus), 71'({1'b1, 5'd4, 32'h0000_2000}));
    chk("lw_en", 71'(data_sram_en), 71'd1);
    chk("lw_we", 71'(data_sram_we), 71'd0);
    step();
    issue(mk(3'b000, ALU_ADD, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1, 32'd1, 32'd0, 32'h1C00_0304),
          ex(1'b0, 1'b0, 5'd0, 32'd2, 32'h1C00_0304), 1'b1);
    @(negedge clk);
    chk("nowe_fwd_dest", 71'(pipe.es_to_ds_bus[37:32]), 71'd0);
    drain();

    div_run("div_s", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'h1C00_0400);
    div_run("mod_s", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'h1C00_0404);
    div_run("div_min", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1C00_0408);
    div_run("mod_z", 3'b101, 32'd9, 32'd0, 32'd9, 32'h1C00_040C);

    pipe.ms_allowin = 1'b0;
    issue(mk(3'b100, ALU_ADD, 1'b0, 1'b1, 1'b0, 5'd6, 32'd9, 32'd0, 32'd0, 32'h1C00_0500),
          ex(1'b0, 1'b1, 5'd6, HAS_DIV ? 32'hFFFF_FFFF : 32'd0, 32'h1C00_0500), 1'b1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pipe.es_to_ms_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("divz_done", 71'(got), 71'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("divz_hold_valid", 71'(pipe.es_to_ms_valid), 71'd1);
      chk("divz_hold_res", 71'(pipe.es_to_ms_bus[63:32]), HAS_DIV ? 71'hFFFF_FFFF : 71'd0);
    end
    step();
    pipe.ms_allowin = 1'b1;
    drain();

    issue(mk(3'b100, ALU_ADD, 1'b0, 1'b1, 1'b0, 5'd7, 32'd100, 32'd3, 32'd0, 32'h1C00_0600),
          ex(1'b0, 1'b1, 5'd7, 32'd0, 32'h1C00_0600), !HAS_DIV);
    repeat (11) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_div_valid", 71'(pipe.es_to_ms_valid), 71'd0);
      chk("rst_div_blk", 71'(pipe.es_to_ds_bus[37]), 71'd0);
      step();
    end
    issue(mk(3'b000, ALU_ADD, 1'b0, 1'b1, 1'b0, 5'd2, 32'd1, 32'd2, 32'd0, 32'h1C00_0700),
          ex(1'b0, 1'b1, 5'd2, 32'd3, 32'h1C00_0700), 1'b1);
    @(negedge clk);
    chk("post_rst_add_valid", 71'(pipe.es_to_ms_valid), 71'd1);
    drain();
    div_run("post_rst_div", 3'b100, 32'd20, 32'd3, 32'd6, 32'h1C00_0704);

    chk("queue_empty", 71'(exp_q.size()), 71'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
